// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and helpers that classify an op code.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNT_W    = $clog2(XLEN_DEF + 1);

  typedef enum logic [3:0] {
    MULT  = 4'd0,
    MULTU = 4'd1,
    DIV   = 4'd2,
    DIVU  = 4'd3,
    MADD  = 4'd4,
    MADDU = 4'd5,
    MSUB  = 4'd6,
    MSUBU = 4'd7,
    MTHI  = 4'd8,
    MTLO  = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  function automatic logic is_mul(input op_e op);
    return op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic is_div(input op_e op);
    return op inside {DIV, DIVU};
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return op inside {MULT, DIV, MADD, MSUB};
  endfunction

  function automatic logic is_madd(input op_e op);
    return op inside {MADD, MADDU};
  endfunction

  function automatic logic is_msub(input op_e op);
    return op inside {MSUB, MSUBU};
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider on unsigned magnitudes; quot_o/rem_o are
// the values this cycle's iteration produces, so the final edge can consume them.
module div_radix2 #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o,
  output logic            last_o
);

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   shl_s;
  logic [XLEN:0]   diff_s;

  // One trial subtraction; a borrow out of the top bit means "restore".
  always_comb begin
    shl_s  = {rem_q, quot_q[XLEN-1]};
    diff_s = shl_s - {1'b0, dvs_q};
    if (diff_s[XLEN]) begin
      rem_o  = shl_s[XLEN-1:0];
      quot_o = {quot_q[XLEN-2:0], 1'b0};
    end else begin
      rem_o  = diff_s[XLEN-1:0];
      quot_o = {quot_q[XLEN-2:0], 1'b1};
    end
  end

  assign last_o = (cnt_q == CW'(1));

  // Iteration registers; the dividend shifts out of quot_q as quotient bits enter.
  always_ff @(posedge clk) begin
    if (reset || abort_i) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else if (start_i) begin
      quot_q <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      cnt_q  <= CW'(XLEN);
    end else if (cnt_q != '0) begin
      quot_q <= quot_o;
      rem_q  <= rem_o;
      cnt_q  <= cnt_q - 1'b1;
    end else begin
      cnt_q  <= cnt_q;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: owns HI/LO, runs one mul/div op at a time behind a
// valid/ready handshake, and supports flush via cancel.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int MCW = 3;

  state_e            state_q, state_d;
  op_e               op_q, op_d, op_s;
  logic [MCW-1:0]    mcnt_q, mcnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d, negq_q, negq_d, negr_q, negr_d;
  logic [2*XLEN-1:0] pipe_q [MUL_STAGES];
  logic [2*XLEN-1:0] ea_s, eb_s, prod_s, acc_s;
  logic              accept_s, sgn_s, div_start_s, div_abort_s, div_last_s;
  logic [XLEN-1:0]   div_a_s, div_b_s, quot_s, rem_s;

  assign op_s      = op_e'(req_op);
  assign sgn_s     = is_signed_op(op_s);
  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept_s  = req_valid && req_ready && !cancel;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

  // Operands extended to full product width; the truncated product is then correct for both signednesses.
  assign ea_s    = {{XLEN{sgn_s & req_a[XLEN-1]}}, req_a};
  assign eb_s    = {{XLEN{sgn_s & req_b[XLEN-1]}}, req_b};
  assign prod_s  = ea_s * eb_s;
  assign div_a_s = (sgn_s && req_a[XLEN-1]) ? -req_a : req_a;
  assign div_b_s = (sgn_s && req_b[XLEN-1]) ? -req_b : req_b;

  // Product pipe: stage 0 captures at the accept edge, last stage is consumed at completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_STAGES; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= prod_s;
      for (int i = 1; i < MUL_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Accumulate against HI/LO as they stand at the completing edge.
  always_comb begin
    if (is_madd(op_q)) begin
      acc_s = {hi_q, lo_q} + pipe_q[MUL_STAGES-1];
    end else if (is_msub(op_q)) begin
      acc_s = {hi_q, lo_q} - pipe_q[MUL_STAGES-1];
    end else begin
      acc_s = pipe_q[MUL_STAGES-1];
    end
  end

  div_radix2 #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start_s),
    .abort_i    (div_abort_s),
    .dividend_i (div_a_s),
    .divisor_i  (div_b_s),
    .quot_o     (quot_s),
    .rem_o      (rem_s),
    .last_o     (div_last_s)
  );

  // Next-state, HI/LO update and divider control.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mcnt_d      = mcnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    dz_d        = dz_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    div_start_s = 1'b0;
    div_abort_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d = op_s;
          if (is_mul(op_s)) begin
            state_d = S_MUL;
            mcnt_d  = MCW'(MUL_STAGES - 1);
          end else if (is_div(op_s)) begin
            state_d     = S_DIV;
            dz_d        = (req_b == '0);
            div_start_s = (req_b != '0);
            negq_d      = sgn_s & (req_a[XLEN-1] ^ req_b[XLEN-1]);
            negr_d      = sgn_s & req_a[XLEN-1];
          end else if (op_s == MTHI) begin
            hi_d = req_a;
          end else if (op_s == MTLO) begin
            lo_d = req_a;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (mcnt_q == '0) begin
          state_d      = S_IDLE;
          done_d       = 1'b1;
          {hi_d, lo_d} = acc_s;
        end else begin
          mcnt_d = mcnt_q - 1'b1;
        end
      end
      S_DIV: begin
        if (cancel) begin
          state_d     = S_IDLE;
          div_abort_s = 1'b1;
        end else if (dz_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (div_last_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          lo_d    = negq_q ? -quot_s : quot_s;
          hi_d    = negr_q ? -rem_s : rem_s;
        end else begin
          state_d = S_DIV;
        end
      end
      default: begin
        state_d     = S_IDLE;
        div_abort_s = 1'b1;
      end
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= MULT;
      mcnt_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mcnt_q  <= mcnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

endmodule
